// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the FP16 multiply back end.
// Holds the FP16 encoding constants, the carry-save operand widths and the
// stage-1 payload carried between the pipeline registers of mul_cs_resolve.
package mul_pkg;

  localparam int          FP16_BIAS  = 15;
  localparam logic [15:0] FP16_QNAN  = 16'h7E00;
  localparam logic [14:0] FP16_INF   = 15'h7C00;

  localparam int CS_A_W     = 24;
  localparam int CS_B_W     = 19;
  localparam int CS_B_SHIFT = 5;

  // Resolved product plus everything round/pack needs one stage later.
  typedef struct packed {
    logic [CS_A_W-1:0] p;
    logic              sign;
    logic [5:0]        exp_sum;
    logic              zero;
    logic              inf;
    logic              nan;
  } s1_payload_t;

endpackage

// File: rtl/mul_round_pack.sv
// mul_round_pack: combinational normalize / round / pack of a resolved
// mantissa product into an IEEE binary16 word.
// Config macro: MUL_CS_RESOLVE_RNE_EN (defined = round-to-nearest-even,
// undefined = truncation).
// Ports:
//   p_i        resolved product, only [21:0] is meaningful
//   sign_i     product sign
//   exp_sum_i  biased exponent sum e1+e2
//   zero_i / inf_i / nan_i  special-case flags
//   data_o     packed FP16 result
//   ovf_o      overflow to infinity
//   unf_o      underflow flushed to zero
module mul_round_pack
  import mul_pkg::*;
#(
  parameter int BIAS = FP16_BIAS
) (
  input  logic [CS_A_W-1:0] p_i,
  input  logic              sign_i,
  input  logic [5:0]        exp_sum_i,
  input  logic              zero_i,
  input  logic              inf_i,
  input  logic              nan_i,
  output logic [15:0]       data_o,
  output logic              ovf_o,
  output logic              unf_o
);

  logic        n;
  logic [9:0]  mant;
  logic        carry;
  logic [10:0] mant_sum;
  logic [9:0]  mant_r;
  logic        rc;
  logic [7:0]  e;

  // Bits 23:22 are zero for legal operands.
  logic unused_p_top;
  assign unused_p_top = ^p_i[23:22];

  assign n    = p_i[21];
  assign mant = n ? p_i[20:11] : p_i[19:10];

`ifdef MUL_CS_RESOLVE_RNE_EN
  logic guard;
  logic sticky;
  assign guard  = n ? p_i[10] : p_i[9];
  assign sticky = n ? (|p_i[9:0]) : (|p_i[8:0]);
  assign carry  = guard & (sticky | mant[0]);
`else
  logic unused_p_low;
  assign unused_p_low = ^p_i[8:0];
  assign carry        = 1'b0;
`endif

  // A wrap out of 10 bits leaves mant_r at zero and bumps the exponent.
  assign mant_sum = {1'b0, mant} + {10'b0, carry};
  assign mant_r   = mant_sum[9:0];
  assign rc       = mant_sum[10];

  // 8-bit two's complement; exp_sum range keeps this within -15..47.
  assign e = {2'b00, exp_sum_i} - 8'(BIAS) + {7'b0, n} + {7'b0, rc};

  always_comb begin
    data_o = {sign_i, e[4:0], mant_r};
    ovf_o  = 1'b0;
    unf_o  = 1'b0;
    if (nan_i) begin
      data_o = FP16_QNAN;
    end else if (inf_i) begin
      data_o = {sign_i, FP16_INF};
    end else if (zero_i) begin
      data_o = {sign_i, 15'h0};
    end else if ($signed(e) >= 8'sd31) begin
      data_o = {sign_i, FP16_INF};
      ovf_o  = 1'b1;
    end else if ($signed(e) <= 8'sd0) begin
      data_o = {sign_i, 15'h0};
      unf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/mul_cs_resolve.sv
// mul_cs_resolve: back end of the FP16 multiply path. Resolves the
// carry-save mantissa pair, then normalizes, rounds and packs the result in
// a 2-stage valid/ready pipeline (one result per cycle).
// Config macro: MUL_CS_RESOLVE_RNE_EN (rounding mode, see mul_round_pack).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake
//   in_cs_a, in_cs_b       carry-save pair (cs_b weighted 2^5)
//   in_sign, in_exp_sum    product sign and biased exponent sum
//   in_zero/inf/nan        special-case flags
//   out_valid / out_ready  downstream handshake
//   out_data, out_ovf, out_unf  FP16 result and flags
module mul_cs_resolve
  import mul_pkg::*;
#(
  parameter int BIAS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CS_A_W-1:0] in_cs_a,
  input  logic [CS_B_W-1:0] in_cs_b,
  input  logic              in_sign,
  input  logic [5:0]        in_exp_sum,
  input  logic              in_zero,
  input  logic              in_inf,
  input  logic              in_nan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_ovf,
  output logic              out_unf
);

  logic              s1_valid_q;
  s1_payload_t       s1_q;
  s1_payload_t       s1_d;
  logic              out_valid_q;
  logic [15:0]       out_data_q;
  logic              out_ovf_q;
  logic              out_unf_q;

  logic              s2_adv;
  logic              s1_adv;
  logic [CS_B_W-1:0] p_hi;
  logic [15:0]       rp_data;
  logic              rp_ovf;
  logic              rp_unf;

  assign s2_adv   = !out_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Final carry-propagate add: the carry word lines up with cs_a[23:5].
  assign p_hi = in_cs_a[CS_A_W-1:CS_B_SHIFT] + in_cs_b;

  always_comb begin
    s1_d         = '0;
    s1_d.p       = {p_hi, in_cs_a[CS_B_SHIFT-1:0]};
    s1_d.sign    = in_sign;
    s1_d.exp_sum = in_exp_sum;
    s1_d.zero    = in_zero;
    s1_d.inf     = in_inf;
    s1_d.nan     = in_nan;
  end

  mul_round_pack #(.BIAS(BIAS)) u_round_pack (
    .p_i       (s1_q.p),
    .sign_i    (s1_q.sign),
    .exp_sum_i (s1_q.exp_sum),
    .zero_i    (s1_q.zero),
    .inf_i     (s1_q.inf),
    .nan_i     (s1_q.nan),
    .data_o    (rp_data),
    .ovf_o     (rp_ovf),
    .unf_o     (rp_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= rp_data;
          out_ovf_q  <= rp_ovf;
          out_unf_q  <= rp_unf;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_mul_cs_resolve.sv
module tb_mul_cs_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_cs_a;
  logic [18:0] in_cs_b;
  logic        in_sign;
  logic [5:0]  in_exp_sum;
  logic        in_zero, in_inf, in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf, out_unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_cs_resolve #(.BIAS(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cs_a    (in_cs_a),
    .in_cs_b    (in_cs_b),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_zero    (in_zero),
    .in_inf     (in_inf),
    .in_nan     (in_nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [23:0] a, input logic [18:0] b, input logic s,
                        input logic [5:0] es, input logic z, input logic i, input logic n);
    in_cs_a = a; in_cs_b = b; in_sign = s; in_exp_sum = es;
    in_zero = z; in_inf = i; in_nan = n;
  endtask

  // One beat with out_ready high: accept on edge N, result checked after N+1.
  task automatic run_vec(input string tag, input logic [23:0] a, input logic [18:0] b,
                         input logic s, input logic [5:0] es, input logic z, input logic i,
                         input logic n, input logic [15:0] exp_d, input logic exp_o,
                         input logic exp_u);
    @(negedge clk);
    set_in(a, b, s, es, z, i, n);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(exp_d));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(exp_o));
    chk({tag, "_unf"},   32'(out_unf),   32'(exp_u));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pat;
  int sent, rcv, cyc, occ;
  logic acc, drn;
  int seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(24'h0, 19'h0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_out_unf",   32'(out_unf),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_vec("one",     24'h100000, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_vec("cs_carry",24'h0FFFE0, 19'h00001, 1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_vec("p21",     24'h240000, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0);
`ifdef MUL_CS_RESOLVE_RNE_EN
    run_vec("round",   24'h100600, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3C02, 1'b0, 1'b0);
    // all-ones mantissa with guard set rounds over into the next binade
    run_vec("rwrap",   24'h1FFE00, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0);
`else
    run_vec("round",   24'h100600, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3C01, 1'b0, 1'b0);
    run_vec("rwrap",   24'h1FFE00, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3FFF, 1'b0, 1'b0);
`endif
    run_vec("tie_even",24'h100200, 19'h0,     1'b0, 6'd30, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0);
    run_vec("ovf",     24'h200000, 19'h0,     1'b0, 6'd46, 1'b0, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b0);
    run_vec("unf",     24'h100000, 19'h0,     1'b1, 6'd15, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_vec("max",     24'h100000, 19'h0,     1'b0, 6'd45, 1'b0, 1'b0, 1'b0, 16'h7800, 1'b0, 1'b0);
    run_vec("nan",     24'h100000, 19'h0,     1'b1, 6'd30, 1'b0, 1'b1, 1'b1, 16'h7E00, 1'b0, 1'b0);
    run_vec("inf",     24'h100000, 19'h0,     1'b1, 6'd30, 1'b1, 1'b1, 1'b0, 16'hFC00, 1'b0, 1'b0);
    run_vec("zero",    24'h100000, 19'h0,     1'b1, 6'd30, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0);

    // Stream 8 beats (mantissa k -> 0x3C00+k) against a fixed ready pattern.
    pat = 32'hB34D2EC5;
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 32];
      in_valid  = (sent < 8);
      set_in(24'h100000 + 24'(sent) * 24'h400, 19'h0, 1'b0, 6'd30, 1'b0, 1'b0, 1'b0);
      #1;
      occ = sent - rcv;
      chk("stream_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn) chk("stream_data", 32'(out_data), 32'h3C00 + 32'(rcv));
      @(posedge clk);
      if (acc) sent++;
      if (drn) rcv++;
      cyc++;
    end
    chk("stream_count", 32'(rcv), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Two beats in flight, stalled, then reset.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(24'h240000, 19'h0, 1'b0, 6'd30, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_data", 32'(out_data), 32'h4080);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_emit", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
